// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage with a local word-organised data RAM.
// Takes the ALU result as the byte address (or as a pass-through result), performs
// byte/half/word loads and stores, and registers the MEM/WB boundary.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall, flush        hold / bubble the MEM/WB register; both suppress the store
//   valid_in            EX/MEM slot holds a real instruction
//   alu_out             ALU result / byte address
//   store_data          store operand (low byte/half used for sub-word stores)
//   mem_read, mem_write load / store (both set behaves as a store)
//   mem_size            00 byte, 01 half, 10 word, 11 illegal
//   mem_unsigned        zero-extend sub-word loads when 1, sign-extend when 0
//   reg_write_in, rd_in register-file write intent and destination
//   valid_out, wb_data, rd_out, reg_write_out   MEM/WB slot
//   misaligned, addr_fault                      per-slot access status
module mem_stage #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        reg_write_in,
  input  logic [4:0]  rd_in,
  output logic        valid_out,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        misaligned,
  output logic        addr_fault
);

  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);
  localparam logic [1:0]  SZ_BYTE    = 2'b00;
  localparam logic [1:0]  SZ_HALF    = 2'b01;
  localparam logic [1:0]  SZ_WORD    = 2'b10;
  localparam logic [1:0]  SZ_ILL     = 2'b11;

  logic [31:0] ram [DEPTH_WORDS];

  logic          is_mem;
  logic          out_of_range;
  logic          misaligned_c;
  logic          addr_fault_c;
  logic          fault;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic [31:0]   rdata;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   load_val;
  logic          store_en;
  logic [3:0]    byte_en;
  logic [31:0]   wdata;

  logic        valid_d, valid_q;
  logic [31:0] wb_data_d, wb_data_q;
  logic [4:0]  rd_d, rd_q;
  logic        reg_write_d, reg_write_q;
  logic        misaligned_d, misaligned_q;
  logic        addr_fault_d, addr_fault_q;

  // Address decode; range fault wins over alignment so only one flag is ever set.
  always_comb begin
    is_mem       = mem_read | mem_write;
    out_of_range = ({1'b0, alu_out} >= BYTE_LIMIT) || (mem_size == SZ_ILL);
    addr_fault_c = is_mem & out_of_range;
    misaligned_c = is_mem & ~out_of_range &
                   (((mem_size == SZ_HALF) & alu_out[0]) |
                    ((mem_size == SZ_WORD) & (alu_out[1:0] != 2'b00)));
    fault        = addr_fault_c | misaligned_c;
    lane         = alu_out[1:0];
    word_idx     = alu_out[AW+1:2];
  end

  // Combinational load path: lane extraction and sign/zero extension.
  always_comb begin
    rdata = ram[word_idx];
    rbyte = rdata[{lane, 3'b000} +: 8];
    rhalf = lane[1] ? rdata[31:16] : rdata[15:0];
    case (mem_size)
      SZ_BYTE: load_val = {{24{~mem_unsigned & rbyte[7]}}, rbyte};
      SZ_HALF: load_val = {{16{~mem_unsigned & rhalf[15]}}, rhalf};
      default: load_val = rdata;
    endcase
  end

  // Store lane enables; data is replicated so each lane sees its own slice.
  always_comb begin
    store_en = ~rst & ~flush & ~stall & valid_in & mem_write & ~fault;
    case (mem_size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wdata   = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{store_data[15:0]}};
      end
      SZ_WORD: begin
        byte_en = 4'b1111;
        wdata   = store_data;
      end
      default: begin
        byte_en = 4'b0000;
        wdata   = store_data;
      end
    endcase
  end

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) ram[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // MEM/WB next state: flush > stall > normal; default is hold.
  always_comb begin
    valid_d      = valid_q;
    wb_data_d    = wb_data_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    misaligned_d = misaligned_q;
    addr_fault_d = addr_fault_q;
    if (flush || (!stall && !valid_in)) begin
      valid_d      = 1'b0;
      wb_data_d    = 32'h0;
      rd_d         = 5'd0;
      reg_write_d  = 1'b0;
      misaligned_d = 1'b0;
      addr_fault_d = 1'b0;
    end else if (!stall) begin
      valid_d      = 1'b1;
      rd_d         = rd_in;
      misaligned_d = misaligned_c;
      addr_fault_d = addr_fault_c;
      reg_write_d  = reg_write_in & (rd_in != 5'd0) & ~fault & ~mem_write;
      if (!is_mem)                wb_data_d = alu_out;
      else if (fault || mem_write) wb_data_d = 32'h0;
      else                         wb_data_d = load_val;
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      wb_data_q    <= 32'h0;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      misaligned_q <= 1'b0;
      addr_fault_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      wb_data_q    <= wb_data_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      misaligned_q <= misaligned_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  assign valid_out     = valid_q;
  assign wb_data       = wb_data_q;
  assign rd_out        = rd_q;
  assign reg_write_out = reg_write_q;
  assign misaligned    = misaligned_q;
  assign addr_fault    = addr_fault_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU in the 5-stage pipeline.
- Consumes alu_out as the effective address (or as the pass-through result) and the store operand from EX.
- Performs byte/half/word loads and stores against a local word-organised data RAM.
- Registers the write-back result, destination register and status into the MEM/WB boundary.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the data RAM; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- AW, 8, word-index width; must equal ceil(log2(DEPTH_WORDS)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold the MEM/WB register; suppress the store.
- flush  in  1  insert a bubble; suppress the store.
- valid_in  in  1  EX/MEM slot holds a real instruction.
- alu_out  in  32  ALU result; this is the byte address when mem_read or mem_write is set.
- store_data  in  32  store operand; the low byte or half is used for sub-word stores.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
- mem_unsigned  in  1  zero-extend sub-word loads; when 0, sign-extend.
- reg_write_in  in  1  instruction writes the register file.
- rd_in  in  5  destination register.
- valid_out  out  1  MEM/WB slot valid.
- wb_data  out  32  write-back value.
- rd_out  out  5  destination register.
- reg_write_out  out  1  register-file write enable for WB.
- misaligned  out  1  registered flag: the access in this slot was misaligned.
- addr_fault  out  1  registered flag: the access was out of range or used an illegal mem_size.

Behaviour:
- Reset: at a posedge with rst=1, all outputs clear to 0. RAM contents are not cleared. rst overrides stall and flush.
- Priority at each posedge: rst > flush > stall > normal.
- Flush: valid_out=0, reg_write_out=0, wb_data=0, rd_out=0, misaligned=0, addr_fault=0. No RAM write.
- Stall: all outputs hold their values. No RAM write.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Address decode:
  - word index = alu_out[AW+1:2]; byte lane = alu_out[1:0].
  - Out of range when alu_out >= 4*DEPTH_WORDS or mem_size == 11.
  - Misaligned when a half access has alu_out[0]=1, or a word access has alu_out[1:0] != 00.
  - Out of range takes precedence: a faulting access sets only addr_fault.
- Store: when valid_in & mem_write & in-range & aligned, the RAM is written at the posedge.
  - Little-endian lanes: byte writes lane alu_out[1:0]; half writes lanes {alu_out[1],0}+1 .. +0; word writes all four lanes.
  - Untouched lanes are preserved.
- mem_read and mem_write both set: treated as a store; the load is ignored.
- Load: RAM read is combinational from the current array. The selected lane is extracted and extended per mem_unsigned, then registered into wb_data.
  - A load issued in the cycle after a store to the same word returns the new data.
- Faulting access (misaligned or addr_fault): no RAM write, wb_data=0, reg_write_out=0. valid_out follows valid_in.
- Non-memory instruction (mem_read=0, mem_write=0): wb_data=alu_out, misaligned=0, addr_fault=0.
- Stores: reg_write_out=0 and wb_data=0.
- reg_write_out = valid_in & reg_write_in & (rd_in != 0) & no fault & !mem_write.
- rd_out = rd_in when valid_in=1, else 0.
- valid_in=0: the slot is a bubble. Outputs are as for flush, except that stall still holds.
- Status flags are per-slot, not sticky.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs → all outputs 0; then a pass-through with alu_out=32'h0000_0003, rd_in=5, reg_write_in=1 → next cycle wb_data=3, rd_out=5, reg_write_out=1, valid_out=1.
- Word store then load:
  - Store 32'hDEAD_BEEF at address 8.
  - Byte load at 9, unsigned → wb_data=32'h0000_00BE.
  - Byte load at 11, signed → 32'hFFFF_FFDE.
  - Half load at 10, signed → 32'hFFFF_DEAD.
  - Word load at 8 → 32'hDEAD_BEEF.
- Sub-word store merge: word 0 = 32'h1122_3344, then byte store 8'hAA at address 2 → word load at 0 returns 32'h11AA_3344.
- Faults:
  - Half load at address 5 → misaligned=1, reg_write_out=0, wb_data=0.
  - Word store at 4*DEPTH_WORDS → addr_fault=1, and no RAM word changes (checked by readback of words 0 and DEPTH_WORDS-1).
  - mem_size=11 → addr_fault=1.
- Stall/flush:
  - A word store asserted during stall=1 → RAM unchanged, outputs held.
  - stall=1 and flush=1 together → bubble, no write.
  - Release stall → the store commits at the next edge.
- Store with rd_in=0: store plus reg_write_in=1, rd_in=0 → reg_write_out=0.
- Pass-through: alu_out=7 with rd_in=0, reg_write_in=1 → wb_data=7, reg_write_out=0.
